id_stage: RTL
=============

Name: id_stage

Overview:
- Decode stage of the 5-stage in-order pipeline. Sits directly downstream of the fetch stage and directly upstream of the execute stage.
- Latches `{inst, pc}` from fetch through the valid/allowin handshake.
- Decodes RV32I base integer instructions and reads the register file.
- Resolves branches and jumps in decode, then returns `{br_jmp, br_jmp_dst}` to fetch. The architecture has exactly one branch delay slot: fetch is never flushed.
- Interlocks on RAW hazards against the EX, MEM and WB stage destinations. The pipeline has no forwarding.

Parameters:
- `RESET_PC`, default `32'h7FFF_FFFC`: value loaded into the latched pc on reset. It is never visible downstream.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high.
- `if_to_id_valid`  in  1  fetch holds a valid instruction.
- `if_to_id_bus`  in  `IF_TO_ID_BUS_WD`(64)  `{inst[31:0], pc[31:0]}`.
- `id_allowin`  out  1  decode can accept this cycle.
- `id_to_if_brbus`  out  `ID_TO_IF_BRBUS_WD`(33)  `{br_jmp, br_jmp_dst[31:0]}`.
- `ex_allowin`  in  1  execute can accept.
- `id_to_ex_valid`  out  1  decode output is valid.
- `id_to_ex_bus`  out  `ID_TO_EX_BUS_WD`(152)  decoded bundle; layout below.
- `ws_to_rf_bus`  in  `WS_TO_RF_BUS_WD`(38)  `{rf_we, rf_waddr[4:0], rf_wdata[31:0]}`.
- `es_dest`  in  5  destination register of a valid EX instruction; 0 if none.
- `ms_dest`  in  5  destination register of a valid MEM instruction; 0 if none.
- `ws_dest`  in  5  destination register of a valid WB instruction; 0 if none.

Behaviour:
- Handshake:
  - `id_ready_go = !hazard`
  - `id_allowin = !id_valid | (id_ready_go & ex_allowin)`
  - `id_to_ex_valid = id_valid & id_ready_go`
- `id_valid` update rules:
  - Cleared on reset.
  - When `id_allowin` is high, `id_valid` takes `if_to_id_valid`.
  - `{inst, pc}` are latched only when `if_to_id_valid & id_allowin`. Otherwise they hold, including throughout a stall.
- Reset values:
  - `id_valid = 0`, so `id_to_ex_valid = 0`.
  - `id_allowin = 1`.
  - `br_jmp = 0`.
  - Latched `inst = 0`; latched `pc = RESET_PC`.
- Latency: one cycle from acceptance to `id_to_ex_valid`, when no hazard is present. The output bus is combinational from the latched instruction and the register file.
- Hazard:
  - Raised when a source register is used, is nonzero, and equals any nonzero `es_dest`, `ms_dest` or `ws_dest`.
  - `rs1` is used by all instructions except LUI, AUIPC and JAL.
  - `rs2` is used by branches, stores and OP (R-type).
  - While the hazard holds, decode keeps its contents and forces `br_jmp = 0`.
- Branch:
  - `br_jmp = id_valid & id_ready_go & taken`.
  - Taken for JAL and JALR, and for BEQ, BNE, BLT, BGE, BLTU and BGEU when their compare on the register values is true.
  - Branch and JAL target is `pc + imm`. JALR target is `(rs1 + imm) & ~1`.
  - When `br_jmp = 0`, `br_jmp_dst` is don't-care; drive it as 0.
- Link: JAL and JALR write `rd` with `pc + 8`, because of the delay slot. This is encoded as `src1_is_pc = 1`, `imm = 8`, `alu_op = add`.
- `id_to_ex_bus`, MSB to LSB:
  - `alu_op[10:0]`, one-hot: add, sub, slt, sltu, and, or, xor, sll, srl, sra, lui.
  - `src1_is_pc`, `src2_is_imm`.
  - `mem_we`, `mem_re`, `mem_size[1:0]` (0 = byte, 1 = half, 2 = word), `mem_unsigned`.
  - `rf_we`, `dest[4:0]`.
  - `imm[31:0]`, sign-extended according to the I/S/B/U/J format.
  - `rs1_val[31:0]`, `rs2_val[31:0]`, `pc[31:0]`.
- `rf_we` is forced to 0 when `rd = 0`. `dest` is driven as 0 whenever `rf_we = 0`.
- Illegal, FENCE and SYSTEM opcodes decode as a NOP: all enables 0 and `alu_op = add`. No trap is raised.
- Register file:
  - 32×32, two asynchronous read ports, one synchronous write port.
  - `x0` reads as 0 and writes to it are ignored.
  - No write-through: the interlock on `ws_dest` covers the same-cycle write.
  - Contents are not reset.
- Reset mid-stall: the next cycle has `id_valid = 0` and `br_jmp = 0`. Pending hazards are dropped.

Decomposition:
- Additions to `DEFWIDTH.v`: `ID_TO_EX_BUS_WD` (152) and `WS_TO_RF_BUS_WD` (38). It already defines `IF_TO_ID_BUS_WD` and `ID_TO_IF_BRBUS_WD`.
- New shared `RV32_OPC.v`: opcode, funct3 and `alu_op` bit-index constants.
- Sub-module `regfile_2r1w` (32×32, `x0` hardwired zero). Decode, immediate generation and branch compare stay inline.

Test Plan:
- ADDI x1,x0,5 at pc `0x8000_0000`, `ex_allowin = 1` → next cycle `id_to_ex_valid = 1`, `alu_op = add`, `src2_is_imm = 1`, `imm = 5`, `dest = 1`, `rf_we = 1`, `rs1_val = 0`.
- BEQ x2,x3,+16 at pc `0x8000_0010` with x2 = x3 = 7 → `br_jmp = 1`, `br_jmp_dst = 0x8000_0020` for one cycle. With x3 = 8 → `br_jmp = 0`.
- JALR x1,x5,3 with x5 = `0x8000_1000`, pc `0x8000_0040` → `br_jmp_dst = 0x8000_1002`, `dest = 1`, `src1_is_pc = 1`, `imm = 8`.
- ADD x4,x1,x2 with `es_dest = 1` for 2 cycles, then 0 → `id_ready_go = 0` and `id_allowin = 0` for 2 cycles; `id_to_ex_valid` asserts on cycle 3; latched inst unchanged.
- `ex_allowin = 0` while `id_valid = 1` → `id_allowin = 0` and the bus holds. A new `if_to_id_valid` is not latched until `ex_allowin = 1`.
- WB writes x9 = `0xDEAD_BEEF`, then SW x9,0(x0) is decoded → `rs2_val = 0xDEAD_BEEF`, `mem_we = 1`, `mem_size = 2`, `rf_we = 0`, `dest = 0`. A write to x0 followed by a read of x0 gives 0.

Source files
------------

// File: rtl/id_stage_pkg.sv
// id_stage_pkg: bus widths, RV32I opcodes, ALU op indices and decode helpers.
package id_stage_pkg;
  localparam int IF_TO_ID_BUS_WD = 64;
  localparam int ID_TO_IF_BRBUS_WD = 33;
  localparam int ID_TO_EX_BUS_WD = 152;
  localparam int WS_TO_RF_BUS_WD = 38;
  typedef enum logic [6:0] {
    OPC_LUI    = 7'b0110111,
    OPC_AUIPC  = 7'b0010111,
    OPC_JAL    = 7'b1101111,
    OPC_JALR   = 7'b1100111,
    OPC_BRANCH = 7'b1100011,
    OPC_LOAD   = 7'b0000011,
    OPC_STORE  = 7'b0100011,
    OPC_OPIMM  = 7'b0010011,
    OPC_OP     = 7'b0110011
  } opcode_e;
  localparam int ALU_ADD = 0;
  localparam int ALU_SUB = 1;
  localparam int ALU_SLT = 2;
  localparam int ALU_SLTU = 3;
  localparam int ALU_AND = 4;
  localparam int ALU_OR = 5;
  localparam int ALU_XOR = 6;
  localparam int ALU_SLL = 7;
  localparam int ALU_SRL = 8;
  localparam int ALU_SRA = 9;
  localparam int ALU_LUI = 10;
  typedef struct packed {
    logic [10:0] alu_op;
    logic        src1_is_pc;
    logic        src2_is_imm;
    logic        mem_we;
    logic        mem_re;
    logic [1:0]  mem_size;
    logic        mem_unsigned;
    logic        rf_we;
    logic [4:0]  dest;
    logic [31:0] imm;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] pc;
  } id_to_ex_t;
  function automatic logic [10:0] alu1h(input int idx);
    return 11'(1) << idx;
  endfunction
  function automatic logic [10:0] op_alu(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000: return alt ? alu1h(ALU_SUB) : alu1h(ALU_ADD);
      3'b001: return alu1h(ALU_SLL);
      3'b010: return alu1h(ALU_SLT);
      3'b011: return alu1h(ALU_SLTU);
      3'b100: return alu1h(ALU_XOR);
      3'b101: return alt ? alu1h(ALU_SRA) : alu1h(ALU_SRL);
      3'b110: return alu1h(ALU_OR);
      default: return alu1h(ALU_AND);
    endcase
  endfunction
  function automatic logic br_cmp(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    case (f3)
      3'b000: return a == b;
      3'b001: return a != b;
      3'b100: return $signed(a) < $signed(b);
      3'b101: return $signed(a) >= $signed(b);
      3'b110: return a < b;
      3'b111: return a >= b;
      default: return 1'b0;
    endcase
  endfunction
endpackage

// File: rtl/id_stage_regfile_2r1w.sv
// regfile_2r1w: 32x32 register file, two async reads, one sync write, x0 hardwired zero.
module regfile_2r1w (
  input  logic        clk,
  input  logic [4:0]  raddr1,
  output logic [31:0] rdata1,
  input  logic [4:0]  raddr2,
  output logic [31:0] rdata2,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata
);
  logic [31:0] rf [32];
  always_ff @(posedge clk)
    if (we && waddr != 5'd0) rf[waddr] <= wdata;
  assign rdata1 = raddr1 == 5'd0 ? 32'd0 : rf[raddr1];
  assign rdata2 = raddr2 == 5'd0 ? 32'd0 : rf[raddr2];
endmodule

// File: rtl/id_stage.sv
// id_stage: RV32I decode with register read, branch resolution in decode and RAW interlock.
module id_stage
  import id_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h7FFF_FFFC
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         if_to_id_valid,
  input  logic [IF_TO_ID_BUS_WD-1:0]   if_to_id_bus,
  output logic                         id_allowin,
  output logic [ID_TO_IF_BRBUS_WD-1:0] id_to_if_brbus,
  input  logic                         ex_allowin,
  output logic                         id_to_ex_valid,
  output logic [ID_TO_EX_BUS_WD-1:0]   id_to_ex_bus,
  input  logic [WS_TO_RF_BUS_WD-1:0]   ws_to_rf_bus,
  input  logic [4:0]                   es_dest,
  input  logic [4:0]                   ms_dest,
  input  logic [4:0]                   ws_dest
);
  logic        id_valid_q;
  logic [31:0] inst_q, pc_q;
  logic [31:0] rs1_val, rs2_val, imm_i, imm_s, imm_b, imm_u, imm_j, tgt;
  logic [6:0]  opc;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  f3;
  logic        rs1_use, rs2_use, taken, hazard, id_ready_go, br_jmp;
  id_to_ex_t   dec;
  assign opc = inst_q[6:0];
  assign rd = inst_q[11:7];
  assign f3 = inst_q[14:12];
  assign rs1 = inst_q[19:15];
  assign rs2 = inst_q[24:20];
  assign imm_i = {{20{inst_q[31]}}, inst_q[31:20]};
  assign imm_s = {{20{inst_q[31]}}, inst_q[31:25], inst_q[11:7]};
  assign imm_b = {{19{inst_q[31]}}, inst_q[31], inst_q[7], inst_q[30:25], inst_q[11:8], 1'b0};
  assign imm_u = {inst_q[31:12], 12'd0};
  assign imm_j = {{11{inst_q[31]}}, inst_q[31], inst_q[19:12], inst_q[20], inst_q[30:21], 1'b0};
  regfile_2r1w u_rf (
    .clk    (clk),
    .raddr1 (rs1),
    .rdata1 (rs1_val),
    .raddr2 (rs2),
    .rdata2 (rs2_val),
    .we     (ws_to_rf_bus[37]),
    .waddr  (ws_to_rf_bus[36:32]),
    .wdata  (ws_to_rf_bus[31:0])
  );
  always_comb begin
    dec = '0;
    dec.alu_op = alu1h(ALU_ADD);
    dec.rs1_val = rs1_val;
    dec.rs2_val = rs2_val;
    dec.pc = pc_q;
    rs1_use = 1'b1;
    rs2_use = 1'b0;
    taken = 1'b0;
    tgt = pc_q + imm_b;
    case (opc)
      OPC_LUI:    begin dec.alu_op = alu1h(ALU_LUI); dec.src2_is_imm = 1'b1; dec.rf_we = 1'b1; dec.imm = imm_u; rs1_use = 1'b0; end
      OPC_AUIPC:  begin dec.src1_is_pc = 1'b1; dec.src2_is_imm = 1'b1; dec.rf_we = 1'b1; dec.imm = imm_u; rs1_use = 1'b0; end
      // Link value is pc + 8 because the delay slot instruction follows the jump.
      OPC_JAL:    begin dec.src1_is_pc = 1'b1; dec.src2_is_imm = 1'b1; dec.rf_we = 1'b1; dec.imm = 32'd8; rs1_use = 1'b0; taken = 1'b1; tgt = pc_q + imm_j; end
      OPC_JALR:   begin dec.src1_is_pc = 1'b1; dec.src2_is_imm = 1'b1; dec.rf_we = 1'b1; dec.imm = 32'd8; taken = 1'b1; tgt = (rs1_val + imm_i) & ~32'd1; end
      OPC_BRANCH: begin dec.imm = imm_b; rs2_use = 1'b1; taken = br_cmp(f3, rs1_val, rs2_val); end
      OPC_LOAD:   begin dec.mem_re = 1'b1; dec.src2_is_imm = 1'b1; dec.rf_we = 1'b1; dec.imm = imm_i; dec.mem_size = f3[1:0]; dec.mem_unsigned = f3[2]; end
      OPC_STORE:  begin dec.mem_we = 1'b1; dec.src2_is_imm = 1'b1; dec.imm = imm_s; dec.mem_size = f3[1:0]; rs2_use = 1'b1; end
      OPC_OPIMM:  begin dec.alu_op = op_alu(f3, inst_q[30] & (f3 == 3'b101)); dec.src2_is_imm = 1'b1; dec.rf_we = 1'b1; dec.imm = imm_i; end
      OPC_OP:     begin dec.alu_op = op_alu(f3, inst_q[30]); dec.rf_we = 1'b1; rs2_use = 1'b1; end
      default:    ;
    endcase
    dec.rf_we = dec.rf_we & (rd != 5'd0);
    dec.dest = dec.rf_we ? rd : 5'd0;
  end
  assign hazard = (rs1_use && rs1 != 5'd0 && (rs1 == es_dest || rs1 == ms_dest || rs1 == ws_dest))
               || (rs2_use && rs2 != 5'd0 && (rs2 == es_dest || rs2 == ms_dest || rs2 == ws_dest));
  assign id_ready_go = !hazard;
  assign id_allowin = !id_valid_q || (id_ready_go && ex_allowin);
  assign id_to_ex_valid = id_valid_q && id_ready_go;
  assign br_jmp = id_valid_q && id_ready_go && taken;
  assign id_to_if_brbus = {br_jmp, br_jmp ? tgt : 32'd0};
  assign id_to_ex_bus = dec;
  always_ff @(posedge clk)
    if (reset) begin
      id_valid_q <= 1'b0;
      inst_q <= 32'd0;
      pc_q <= RESET_PC;
    end else begin
      if (id_allowin) id_valid_q <= if_to_id_valid;
      if (if_to_id_valid && id_allowin) {inst_q, pc_q} <= if_to_id_bus;
    end
endmodule
